multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS subset: R-format, lw, sw, beq, j.
- Replaces the per-instruction combinational flag decode with a Moore FSM.
- Drives PC, IR, memory, register-file and ALU selects over 3–5 cycles per instruction.
- Handshakes with a shared instruction/data memory that may stall.
- Traps illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, 15: max consecutive mem_ready-low cycles in a memory state before fault (≥1).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch instruction register
- reg_dst  out  1  1 rd, 0 rt
- reg_write  out  1  register file write
- mem_to_reg  out  1  1 MDR, 0 ALUOut
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 per funct
- state  out  4  current state encoding
- fault  out  1  sticky; high in FAULT
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
- instr_retired  out  CNT_W  completed-instruction count

Behaviour:
- State encoding: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, FAULT=15.
- Reset, including mid-instruction: next state RESET; instr_retired=0, fault_code=00, wait counter=0. RESET drives all control outputs 0 and goes to FETCH next cycle.
- Outputs are a Moore decode of state; only pc_write and ir_write in FETCH also depend on mem_ready. Unlisted outputs are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Else hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - 100011 or 101011 → MEMADR.
  - 000000 → EXEC.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - Any other opcode → FAULT, fault_code=01.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEMRD, sw → MEMWR.
- MEMRD: mem_read=1, i_or_d=1. mem_ready → MEMWB, else hold.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH; retire.
- MEMWR: mem_write=1, i_or_d=1. mem_ready → FETCH with retire, else hold.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH; retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH; retire.
- JUMP: pc_write=1, pc_source=10 → FETCH; retire.
- Cycle counts with zero wait: R 4, lw 5, sw 4, beq 3, j 3.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Cleared on entry to each of these states.
  - Increments each cycle mem_ready=0.
  - mem_ready=1 always wins, including on the TIMEOUT-th low-wait cycle.
  - If mem_ready=0 and counter==TIMEOUT-1: next state FAULT, fault_code=10.
- FAULT: all control outputs 0, fault=1; exits only on reset.
- Retire: instr_retired increments by 1 on the cycle the FSM leaves a final state toward FETCH; wraps modulo 2^CNT_W.
- opcode is sampled only in DECODE (and MEMADR for the lw/sw split); changes elsewhere have no effect.

Test Plan:
- Reset 2 cycles, opcode=000000, mem_ready=1 → states 0,1,2,7,8,1; reg_write=1 and reg_dst=1 in ALUWB; instr_retired=1.
- lw (100011), mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles with mem_read=1, i_or_d=1; MEMWB has mem_to_reg=1; total 8 cycles from FETCH; instr_retired+1.
- sw then beq then j back-to-back, ready=1 → 4+3+3 cycles; mem_write one cycle; pc_write_cond with pc_source=01; pc_write with pc_source=10; instr_retired=3.
- FETCH with mem_ready held 0, TIMEOUT=15 → 15 FETCH cycles, then FAULT, fault_code=10, outputs 0. Repeat with ready rising on the 15th cycle → DECODE, no fault.
- opcode=001000 in DECODE → FAULT next cycle, fault_code=01; remains through 20 cycles; reset → RESET, fault=0.
- Reset asserted in MEMWR mid-stall → RESET next cycle, mem_write=0, instr_retired=0; then FETCH.
- CNT_W=2, 5 R-type instructions → instr_retired wraps 3→0→1.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multi-cycle MIPS subset datapath with stall and fault handling
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_retired
);
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_FAULT  = 4'd15
  } state_t;
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
  state_t st, nx;
  logic [WW-1:0] wcnt;
  logic [1:0] fc_nx;
  logic wait_st, expired, retire;
  assign state   = st;
  assign fault   = st == S_FAULT;
  assign wait_st = st inside {S_FETCH, S_MEMRD, S_MEMWR};
  // a ready on the last allowed cycle still completes the access
  assign expired = wait_st && !mem_ready && wcnt == WW'(TIMEOUT - 1);
  assign retire  = nx == S_FETCH && st inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP};
  always_comb begin
    nx            = st;
    fc_nx         = fault_code;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (st)
      S_RESET: nx = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nx        = mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        nx = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
             opcode == OP_R   ? S_EXEC :
             opcode == OP_BEQ ? S_BRANCH :
             opcode == OP_J   ? S_JUMP : S_FAULT;
        fc_nx = nx == S_FAULT ? 2'b01 : fault_code;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nx        = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        nx       = mem_ready ? S_MEMWB : expired ? S_FAULT : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nx         = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        nx        = mem_ready ? S_FETCH : expired ? S_FAULT : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nx        = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nx        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        nx            = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        nx        = S_FETCH;
      end
      S_FAULT: nx = S_FAULT;
      default: nx = S_FAULT;
    endcase
    if (expired) fc_nx = 2'b10;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= S_RESET;
      wcnt          <= '0;
      fault_code    <= 2'b00;
      instr_retired <= '0;
    end else begin
      st            <= nx;
      wcnt          <= (wait_st && nx == st) ? wcnt + 1'b1 : '0;
      fault_code    <= fc_nx;
      instr_retired <= retire ? instr_retired + 1'b1 : instr_retired;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams checked against a per-instruction phase model
module tb_multicycle_control;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
  logic clk = 0, reset = 1, mem_ready = 0;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_write;
  logic mem_to_reg, alu_src_a, fault;
  logic [1:0] pc_source, alu_src_b, alu_op, fault_code;
  logic [3:0] state;
  logic [15:0] instr_retired;
  logic b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_ir_write, b_reg_dst;
  logic b_reg_write, b_mem_to_reg, b_alu_src_a, b_fault;
  logic [1:0] b_pc_source, b_alu_src_b, b_alu_op, b_fault_code;
  logic [3:0] b_state;
  logic [1:0] b_instr_retired;
  int n_chk = 0, n_pass = 0, retired = 0;
  logic [1:0] exp_fc = 2'b00;
  logic [5:0] legal [5] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .fault(fault), .fault_code(fault_code),
    .instr_retired(instr_retired)
  );
  multicycle_control #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .pc_source(b_pc_source),
    .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_dst(b_reg_dst), .reg_write(b_reg_write), .mem_to_reg(b_mem_to_reg),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .state(b_state),
    .fault(b_fault), .fault_code(b_fault_code), .instr_retired(b_instr_retired)
  );
  wire [15:0] ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                     reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};
  wire [15:0] ctl2 = {b_pc_write, b_pc_write_cond, b_pc_source, b_i_or_d, b_mem_read, b_mem_write,
                      b_ir_write, b_reg_dst, b_reg_write, b_mem_to_reg, b_alu_src_a, b_alu_src_b,
                      b_alu_op};
  function automatic logic [15:0] exp_ctl(input int s, input bit rdy);
    logic pw, pwc, iod, mr, mw, irw, rd, rw, m2r, asa;
    logic [1:0] ps, asb, aop;
    {pw, pwc, iod, mr, mw, irw, rd, rw, m2r, asa} = '0;
    {ps, asb, aop} = '0;
    if (s == 1) begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
    if (s == 2) asb = 2'b11;
    if (s == 3) begin asa = 1; asb = 2'b10; end
    if (s == 4) begin mr = 1; iod = 1; end
    if (s == 5) begin rw = 1; m2r = 1; end
    if (s == 6) begin mw = 1; iod = 1; end
    if (s == 7) begin asa = 1; aop = 2'b10; end
    if (s == 8) begin rw = 1; rd = 1; end
    if (s == 9) begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
    if (s == 10) begin pw = 1; ps = 2'b10; end
    return {pw, pwc, ps, iod, mr, mw, irw, rd, rw, m2r, asa, asb, aop};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
  endtask
  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction
  function automatic bit rbit();
    return 1'($urandom);
  endfunction
  task automatic cyc(input int s, input bit rdy, input logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode = op;
    #1;
    check("state", state, s);
    check("ctl", ctl, exp_ctl(s, rdy));
    check("fault", fault, s == 15);
    check("fault_code", fault_code, exp_fc);
    check("retired", instr_retired, retired & 16'hFFFF);
    check("state_w2", b_state, s);
    check("ctl_w2", ctl2, exp_ctl(s, rdy));
    check("retired_w2", b_instr_retired, retired & 3);
  endtask
  task automatic mem_phase(input int s, input int w);
    repeat (w) cyc(s, 0, rnd_op());
    cyc(s, 1, rnd_op());
  endtask
  task automatic instr(input logic [5:0] op, input int wf, input int wm);
    mem_phase(1, wf);
    cyc(2, rbit(), op);
    case (op)
      OP_LW: begin cyc(3, rbit(), op); mem_phase(4, wm); cyc(5, rbit(), rnd_op()); end
      OP_SW: begin cyc(3, rbit(), op); mem_phase(6, wm); end
      OP_R: begin cyc(7, rbit(), rnd_op()); cyc(8, rbit(), rnd_op()); end
      OP_BEQ: cyc(9, rbit(), rnd_op());
      default: cyc(10, rbit(), rnd_op());
    endcase
    retired++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    retired = 0;
    exp_fc = 2'b00;
    cyc(0, rbit(), rnd_op());
    reset = 0;
  endtask
  initial begin
    logic [5:0] ill;
    cyc(0, 1, OP_R);
    cyc(0, 1, OP_R);
    reset = 0;
    instr(OP_R, 0, 0);
    instr(OP_LW, 0, 3);
    instr(OP_SW, 0, 0);
    instr(OP_BEQ, 0, 0);
    instr(OP_J, 0, 0);
    repeat (15) cyc(1, 0, rnd_op());
    exp_fc = 2'b10;
    repeat (3) cyc(15, rbit(), rnd_op());
    do_reset();
    instr(OP_R, 14, 0);
    instr(OP_LW, 0, 14);
    instr(OP_SW, 0, 14);
    mem_phase(1, 2);
    do ill = rnd_op(); while (ill inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J});
    cyc(2, rbit(), ill);
    exp_fc = 2'b01;
    repeat (20) cyc(15, rbit(), rnd_op());
    do_reset();
    mem_phase(1, 1);
    cyc(2, rbit(), OP_SW);
    cyc(3, rbit(), OP_SW);
    cyc(6, 0, rnd_op());
    cyc(6, 0, rnd_op());
    do_reset();
    repeat (5) instr(OP_R, 0, 0);
    mem_phase(4'd1, 0);
    cyc(2, rbit(), OP_LW);
    cyc(3, rbit(), OP_LW);
    repeat (15) cyc(4, 0, rnd_op());
    exp_fc = 2'b10;
    cyc(15, rbit(), rnd_op());
    do_reset();
    repeat (60) instr(legal[$urandom_range(0, 4)], $urandom_range(0, 14), $urandom_range(0, 14));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
